ham_enc_ser: RTL and testbench
==============================

Name: ham_enc_ser

Overview:
- Upstream neighbour of the Hamming(17,12) decoder.
- Accepts 12-bit data words over a valid/ready handshake and encodes each into a 17-bit even-parity Hamming codeword.
- Shifts the codeword out serially as a framed bitstream; a parallel registered copy is also presented for the decoder.
- Serves as the transmit side of the encode/channel/decode chain.

Parameters:
- GAP_CYCLES, 1, idle cycles inserted after each frame before the next word is accepted (0 allowed).
- LSB_FIRST, 1, 1 = codeword bit 0 sent first; 0 = bit 16 sent first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  12  data word.
- ser_out  output  1  serial codeword bit.
- ser_frame  output  1  high while ser_out carries a codeword bit.
- ser_last  output  1  high on the final (17th) bit of a frame.
- cw_out  output  17  registered codeword of the current/last frame.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Codeword index k corresponds to Hamming position k+1.
  - Parity bits sit at indices 0, 1, 3, 7, 15.
  - Data mapping:
    - cw[2] = d[0]
    - cw[6:4] = d[3:1]
    - cw[14:8] = d[10:4]
    - cw[16] = d[11]
- Parity equations (even parity, XOR):
  - cw[0] = ^{cw[2],4,6,8,10,12,14,16}
  - cw[1] = ^{cw[2],5,6,9,10,13,14}
  - cw[3] = ^{cw[4],5,6,11,12,13,14}
  - cw[7] = ^{cw[8..14]}
  - cw[15] = cw[16]
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: in_ready=1. On in_valid&in_ready at edge N, the encoded word is captured into cw_out and the shift register, bit counter is cleared, and the FSM goes to SHIFT.
  - SHIFT: in_ready=0, ser_frame=1, one bit per cycle.
    - First bit is visible in the cycle after edge N.
    - The 17th bit is visible 17 cycles after edge N with ser_last=1.
    - After the last bit: go to GAP if GAP_CYCLES>0, else go to IDLE.
  - GAP: ser_frame=0, ser_out=0; count GAP_CYCLES cycles, then go to IDLE.
- Throughput: one word per 18+GAP_CYCLES cycles. in_valid while not ready is ignored and must be held by the source. in_data is sampled only at the handshake.
- Reset (async, any state, including mid-frame):
  - State goes to IDLE; in_ready=1.
  - ser_out=0, ser_frame=0, ser_last=0, busy=0, cw_out=0.
  - Counters are cleared; a partial frame is abandoned with no ser_last.
- Release of rst takes effect at the next clk edge. in_valid high on the first edge after reset is accepted.
- Bit counter is 5 bits wide and counts 0..16. A wrap past 16 is not reachable.

Optional Feature:
- Macro: HAM_ERR_INJ_EN.
- With the macro defined:
  - Extra inputs err_inj (1 bit) and err_inj_pos (5 bits).
  - If err_inj=1 at the handshake and err_inj_pos<17, bit err_inj_pos of the captured codeword is inverted in both cw_out and the serial stream.
  - err_inj_pos≥17 injects nothing.
- Without the macro: the ports are absent and the codeword is always clean.

Decomposition:
- Package ham_pkg holds:
  - DATA_W=12, CW_W=17, PAR_W=5.
  - Parity index constants (0, 1, 3, 7, 15).
  - The state enum.
  - The package is shared with the decoder.
- Sub-module ham_enc_core is a pure combinational 12→17 encoder, reusable in the decoder bench as a reference model.

Test Plan:
- Reset mid-frame (assert rst after bit 5 of in_data=12'hFFF) -> all outputs 0 immediately; in_ready=1 next cycle; no ser_last seen.
- in_data=12'h001 -> cw_out=17'h00007; LSB_FIRST stream is 1,1,1 followed by fourteen 0s; ser_last on the 17th bit.
- in_data=12'h800 -> cw_out=17'h18001.
- in_data=12'hFFF -> cw_out=17'h1FFFE.
- Back-to-back in_valid held high with GAP_CYCLES=1 -> second accept exactly 19 cycles after the first; in_ready low throughout SHIFT and GAP.
- HAM_ERR_INJ_EN tests:
  - in_data=12'h000 with err_inj=1 and pos=13 -> cw_out=17'h02000; the downstream decoder recovers 12'h000.
  - The same with pos=20 -> cw_out=0.

Source files
------------

// File: rtl/ham_pkg.sv
// Shared Hamming(17,12) constants and FSM state type,
// used by both the encoder/serializer and the decoder.
package ham_pkg;

   localparam int DATA_W = 12;
   localparam int CW_W   = 17;
   localparam int PAR_W  = 5;
   localparam int CNT_W  = 5;

   localparam int P0_IDX = 0;
   localparam int P1_IDX = 1;
   localparam int P2_IDX = 3;
   localparam int P3_IDX = 7;
   localparam int P4_IDX = 15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

endpackage

// File: rtl/ham_enc_ser_if.sv
// Input word handshake bundle for ham_enc_ser.
// Optional error-injection fields exist only with HAM_ERR_INJ_EN.
interface ham_enc_ser_if;
   import ham_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
`ifdef HAM_ERR_INJ_EN
   logic              err_inj;
   logic [4:0]        err_inj_pos;

   modport master (
      output in_valid, in_data, err_inj, err_inj_pos,
      input  in_ready
   );
   modport slave (
      input  in_valid, in_data, err_inj, err_inj_pos,
      output in_ready
   );
`else
   modport master (
      output in_valid, in_data,
      input  in_ready
   );
   modport slave (
      input  in_valid, in_data,
      output in_ready
   );
`endif

endinterface

// File: rtl/ham_enc_core.sv
// Combinational 12->17 even-parity Hamming encoder.
// Index k of the codeword is Hamming position k+1.
module ham_enc_core
   import ham_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   output logic [CW_W-1:0]   cw_o
);

   logic [CW_W-1:0] c;

   always_comb begin
      c         = '0;
      c[2]      = data_i[0];
      c[6:4]    = data_i[3:1];
      c[14:8]   = data_i[10:4];
      c[16]     = data_i[11];
      c[P0_IDX] = ^{c[2], c[4], c[6], c[8],
                    c[10], c[12], c[14], c[16]};
      c[P1_IDX] = ^{c[2], c[5], c[6], c[9],
                    c[10], c[13], c[14]};
      c[P2_IDX] = ^{c[4], c[5], c[6], c[11],
                    c[12], c[13], c[14]};
      c[P3_IDX] = ^c[14:8];
      c[P4_IDX] = c[16];
      cw_o      = c;
   end

endmodule

// File: rtl/ham_enc_ser.sv
// Hamming(17,12) encoder with framed serial output.
// Build option HAM_ERR_INJ_EN adds single-bit error injection.
module ham_enc_ser
   import ham_pkg::*;
#(
   parameter int GAP_CYCLES = 1,
   parameter bit LSB_FIRST  = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   ham_enc_ser_if.slave    in_if,
   output logic            ser_out_o,
   output logic            ser_frame_o,
   output logic            ser_last_o,
   output logic [CW_W-1:0] cw_out_o,
   output logic            busy_o
);

   localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
   localparam logic [GW-1:0] GAP_LAST =
      GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CW_W - 1);

   state_e           state_q, state_d;
   logic [CW_W-1:0]  cw_q, cw_d;
   logic [CW_W-1:0]  sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [CW_W-1:0]  enc_cw, cap_cw;
   logic             accept, last_bit, gap_done, tx_bit;

   ham_enc_core u_core (
      .data_i (in_if.in_data),
      .cw_o   (enc_cw)
   );

`ifdef HAM_ERR_INJ_EN
   logic [CW_W-1:0] inj_mask;

   always_comb begin
      inj_mask = '0;
      if (in_if.err_inj && (in_if.err_inj_pos < 5'(CW_W)))
         inj_mask = CW_W'(1) << in_if.err_inj_pos;
   end

   assign cap_cw = enc_cw ^ inj_mask;
`else
   assign cap_cw = enc_cw;
`endif

   assign accept   = (state_q == ST_IDLE) && in_if.in_valid;
   assign last_bit = (cnt_q == BIT_LAST);
   assign gap_done = (gap_q == GAP_LAST);
   assign tx_bit   = LSB_FIRST ? sr_q[0] : sr_q[CW_W-1];
   assign cw_out_o = cw_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (accept) state_d = ST_SHIFT;
         ST_SHIFT: if (last_bit)
                      state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
         ST_GAP:   if (gap_done) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_if.in_ready = 1'b0;
      ser_frame_o    = 1'b0;
      ser_out_o      = 1'b0;
      ser_last_o     = 1'b0;
      busy_o         = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            in_if.in_ready = 1'b1;
            busy_o         = 1'b0;
         end
         ST_SHIFT: begin
            ser_frame_o = 1'b1;
            ser_out_o   = tx_bit;
            ser_last_o  = last_bit;
         end
         default: ;
      endcase
   end

   // The shift register moves the next bit into the output slot each cycle.
   always_comb begin
      cw_d  = cw_q;
      sr_d  = sr_q;
      cnt_d = cnt_q;
      gap_d = gap_q;
      if (accept) begin
         cw_d  = cap_cw;
         sr_d  = cap_cw;
         cnt_d = '0;
      end else if (state_q == ST_SHIFT) begin
         sr_d  = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
         gap_d = '0;
         if (!last_bit) cnt_d = cnt_q + CNT_W'(1);
      end else if (state_q == ST_GAP) begin
         gap_d = gap_q + GW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cw_q  <= '0;
         sr_q  <= '0;
         cnt_q <= '0;
         gap_q <= '0;
      end else begin
         cw_q  <= cw_d;
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
         gap_q <= gap_d;
      end
   end

endmodule

// File: tb/tb_ham_enc_ser.sv
// Randomized self-checking bench for ham_enc_ser against a
// position-based Hamming reference model.
module tb_ham_enc_ser;
   import ham_pkg::*;

   localparam int GAP = 1;
   localparam bit LSB = 1'b1;

   logic        clk;
   logic        rst;
   logic        ser_out, ser_frame, ser_last, busy;
   logic [16:0] cw_out;
   int          checks   = 0;
   int          failures = 0;

   ham_enc_ser_if bus ();

   ham_enc_ser #(
      .GAP_CYCLES (GAP),
      .LSB_FIRST  (LSB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_if       (bus),
      .ser_out_o   (ser_out),
      .ser_frame_o (ser_frame),
      .ser_last_o  (ser_last),
      .cw_out_o    (cw_out),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data fills non-power-of-two positions in order; parity p_i covers
   // every position whose binary index has bit i set.
   function automatic logic [16:0] ref_enc(input logic [11:0] d);
      logic [16:0] cw;
      logic        par;
      int          j;
      cw = '0;
      j  = 0;
      for (int p = 1; p <= 17; p++)
         if ((p & (p - 1)) != 0) begin
            cw[p-1] = d[j];
            j++;
         end
      for (int i = 0; i < 5; i++) begin
         par = 1'b0;
         for (int p = 1; p <= 17; p++)
            if (((p >> i) & 1) == 1 && p != (1 << i)) par ^= cw[p-1];
         cw[(1 << i) - 1] = par;
      end
      return cw;
   endfunction

`ifdef HAM_ERR_INJ_EN
   function automatic logic [11:0] ref_dec(input logic [16:0] cw);
      logic [16:0] c;
      logic [11:0] d;
      int          s;
      int          j;
      c = cw;
      d = '0;
      s = 0;
      j = 0;
      for (int p = 1; p <= 17; p++)
         if (c[p-1]) s ^= p;
      if (s >= 1 && s <= 17) c[s-1] = ~c[s-1];
      for (int p = 1; p <= 17; p++)
         if ((p & (p - 1)) != 0) begin
            d[j] = c[p-1];
            j++;
         end
      return d;
   endfunction
`endif

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (busy === 1'b0) done = 1'b1;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL wait_idle: busy=%b want 0 within 40 cycles", busy);
      end
   endtask

   task automatic run_frame(input logic [11:0] d, input logic [16:0] exp);
      logic [3:0] got, want;
      logic       b;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_before: got %b want 1", bus.in_ready);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 12'($urandom);
      checks++;
      if (cw_out !== exp) begin
         failures++;
         $display("FAIL cw_out d=%h: got %h want %h", d, cw_out, exp);
      end
      for (int k = 0; k < 17; k++) begin
         if (k > 0) @(negedge clk);
         b    = LSB ? exp[k] : exp[16-k];
         want = {1'b1, b, (k == 16), 1'b0};
         got  = {ser_frame, ser_out, ser_last, bus.in_ready};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL stream d=%h bit%0d {frame,out,last,ready}: got %b want %b",
                     d, k, got, want);
         end
      end
      for (int g = 0; g < GAP; g++) begin
         @(negedge clk);
         checks++;
         if ({ser_frame, ser_out, ser_last, bus.in_ready, busy} !== 5'b00001) begin
            failures++;
            $display("FAIL gap%0d {frame,out,last,ready,busy}: got %b want 00001",
                     g, {ser_frame, ser_out, ser_last, bus.in_ready, busy});
         end
      end
      @(negedge clk);
      checks++;
      if ({bus.in_ready, busy} !== 2'b10) begin
         failures++;
         $display("FAIL idle_after {ready,busy}: got %b want 10",
                  {bus.in_ready, busy});
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({bus.in_ready, busy, ser_frame, ser_out, ser_last, cw_out} !==
          {1'b1, 4'b0000, 17'h0}) begin
         failures++;
         $display("FAIL reset_state: ready=%b busy=%b frame=%b out=%b last=%b cw=%h want 1,0,0,0,0,0",
                  bus.in_ready, busy, ser_frame, ser_out, ser_last, cw_out);
      end
      rst = 1'b0;
   endtask

   task automatic test_vectors();
      run_frame(12'h001, ref_enc(12'h001));
      checks++;
      if (cw_out !== 17'h00007) begin
         failures++;
         $display("FAIL vec_001: got %h want 00007", cw_out);
      end
      run_frame(12'h800, ref_enc(12'h800));
      checks++;
      if (cw_out !== 17'h18001) begin
         failures++;
         $display("FAIL vec_800: got %h want 18001", cw_out);
      end
      run_frame(12'hFFF, ref_enc(12'hFFF));
      checks++;
      if (cw_out !== 17'h1FFFE) begin
         failures++;
         $display("FAIL vec_FFF: got %h want 1FFFE", cw_out);
      end
   endtask

   task automatic test_random();
      logic [11:0] d;
      for (int i = 0; i < 12; i++) begin
         d = 12'($urandom);
         run_frame(d, ref_enc(d));
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [11:0] d;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 12'hFFF;
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int k = 1; k <= 5; k++) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({ser_out, ser_frame, ser_last, busy, cw_out} !== 21'h0) begin
         failures++;
         $display("FAIL mid_reset_outs: out=%b frame=%b last=%b busy=%b cw=%h want all 0",
                  ser_out, ser_frame, ser_last, busy, cw_out);
      end
      @(negedge clk);
      checks++;
      if ({bus.in_ready, ser_last} !== 2'b10) begin
         failures++;
         $display("FAIL mid_reset_ready {ready,last}: got %b want 10",
                  {bus.in_ready, ser_last});
      end
      d            = 12'($urandom);
      rst          = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if ({busy, ser_frame, ser_last, cw_out} !== {3'b110, ref_enc(d)}) begin
         failures++;
         $display("FAIL first_edge_accept: busy=%b frame=%b last=%b cw=%h want 1,1,0,%h",
                  busy, ser_frame, ser_last, cw_out, ref_enc(d));
      end
      wait_idle();
   endtask

   task automatic test_back_to_back();
      logic [11:0] d1, d2;
      int          n;
      bit          seen;
      d1 = 12'($urandom);
      d2 = '0;
      n  = 0;
      seen = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d1;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) begin
            seen = 1'b1;
            n    = i;
            d2   = bus.in_data;
         end else begin
            if (i == 1) begin
               checks++;
               if (cw_out !== ref_enc(d1)) begin
                  failures++;
                  $display("FAIL b2b_first_cw: got %h want %h", cw_out, ref_enc(d1));
               end
            end
            checks++;
            if (busy !== 1'b1) begin
               failures++;
               $display("FAIL b2b_busy cyc%0d: got %b want 1", i, busy);
            end
            bus.in_data = 12'($urandom);
         end
      end
      checks++;
      if (!seen || n != 18 + GAP) begin
         failures++;
         $display("FAIL b2b_spacing: got %0d want %0d (seen=%0b)", n, 18 + GAP, seen);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (cw_out !== ref_enc(d2)) begin
         failures++;
         $display("FAIL b2b_second_cw: got %h want %h", cw_out, ref_enc(d2));
      end
      wait_idle();
   endtask

`ifdef HAM_ERR_INJ_EN
   task automatic test_err_inj();
      logic [11:0] d;
      logic [4:0]  pos;
      logic [16:0] exp;
      bus.err_inj     = 1'b1;
      bus.err_inj_pos = 5'd13;
      run_frame(12'h000, ref_enc(12'h000) ^ (17'h1 << 13));
      checks++;
      if (cw_out !== 17'h02000 || ref_dec(cw_out) !== 12'h000) begin
         failures++;
         $display("FAIL inj_pos13: got cw %h dec %h want 02000 dec 000",
                  cw_out, ref_dec(cw_out));
      end
      bus.err_inj_pos = 5'd20;
      run_frame(12'h000, 17'h0);
      checks++;
      if (cw_out !== 17'h0) begin
         failures++;
         $display("FAIL inj_pos20: got %h want 00000", cw_out);
      end
      for (int i = 0; i < 4; i++) begin
         d   = 12'($urandom);
         pos = 5'($urandom_range(0, 31));
         exp = ref_enc(d);
         if (pos < 17) exp[pos] = ~exp[pos];
         bus.err_inj_pos = pos;
         run_frame(d, exp);
         checks++;
         if (ref_dec(cw_out) !== d) begin
            failures++;
            $display("FAIL inj_decode pos=%0d: got %h want %h", pos, ref_dec(cw_out), d);
         end
      end
      bus.err_inj = 1'b0;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
`ifdef HAM_ERR_INJ_EN
      bus.err_inj     = 1'b0;
      bus.err_inj_pos = '0;
`endif
      test_reset();
      test_vectors();
      test_random();
      test_reset_mid_frame();
      test_back_to_back();
`ifdef HAM_ERR_INJ_EN
      test_err_inj();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
